// File: rtl/ex_seg.sv
// Execute stage: ALU / effective address, HI/LO and a 32-step iterative MULTU/DIVU unit.
// Result is combinational off the input register; MULTU/DIVU stall upstream 33 cycles and send NOPs down.
module ex_seg #(
   parameter int MD_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] A_i,
   input  logic [31:0] B_i,
   input  logic [31:0] Imm_i,
   input  logic [31:0] IR_i,
   output logic        stall,
   output logic [31:0] ALUo_Out,
   output logic [31:0] B_Out,
   output logic [31:0] IR_Out
);

   localparam int CW = $clog2(MD_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(MD_CYCLES - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   logic [31:0]   a_q, b_q, imm_q, ir_q;
   logic [31:0]   hi_q, lo_q;
   logic [31:0]   md_hi, md_lo, md_d;
   logic          md_div;
   logic [CW-1:0] cnt;
   logic [1:0]    state;

   logic [5:0]  opcode, funct;
   logic [4:0]  shamt;
   logic        is_md;
   logic [32:0] mul_sum;
   logic [32:0] div_shift;
   logic [31:0] div_sub;
   logic        div_ge;
   logic [31:0] step_hi, step_lo;
   logic [31:0] alu;

   assign opcode = ir_q[31:26];
   assign funct  = ir_q[5:0];
   assign shamt  = ir_q[10:6];
   assign is_md  = (opcode == OP_RTYPE) && (funct == FN_MULTU || funct == FN_DIVU);

   assign stall    = (state == ST_BUSY) || (state == ST_IDLE && is_md);
   assign IR_Out   = stall ? 32'd0 : ir_q;
   assign B_Out    = b_q;
   assign ALUo_Out = alu;

   // md_hi holds the partial product high word or the running remainder;
   // md_lo holds the multiplier being shifted out or the quotient being shifted in.
   always_comb begin
      mul_sum   = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_d} : 33'd0);
      div_shift = {md_hi, md_lo[31]};
      div_ge    = (div_shift >= {1'b0, md_d});
      // When the trial subtract succeeds the difference is below 2^32, so 32-bit wrap is exact.
      div_sub   = div_shift[31:0] - md_d;
      if (md_div) begin
         step_hi = div_ge ? div_sub : div_shift[31:0];
         step_lo = {md_lo[30:0], div_ge};
      end else begin
         step_hi = mul_sum[32:1];
         step_lo = {mul_sum[0], md_lo[31:1]};
      end
   end

   always_comb begin
      alu = 32'd0;
      if (opcode == OP_RTYPE) begin
         case (funct)
            FN_ADD:  alu = a_q + b_q;
            FN_SUB:  alu = a_q - b_q;
            FN_AND:  alu = a_q & b_q;
            FN_OR:   alu = a_q | b_q;
            FN_XOR:  alu = a_q ^ b_q;
            FN_SLT:  alu = {31'd0, $signed(a_q) < $signed(b_q)};
            FN_SLTU: alu = {31'd0, a_q < b_q};
            FN_SLL:  alu = b_q << shamt;
            FN_SRL:  alu = b_q >> shamt;
            FN_MFHI: alu = hi_q;
            FN_MFLO: alu = lo_q;
            default: alu = 32'd0;
         endcase
      end else begin
         case (opcode)
            OP_ADDI, OP_LW, OP_SW: alu = a_q + imm_q;
            OP_SLTI: alu = {31'd0, $signed(a_q) < $signed(imm_q)};
            OP_ANDI: alu = a_q & {16'd0, imm_q[15:0]};
            OP_ORI:  alu = a_q | {16'd0, imm_q[15:0]};
            OP_LUI:  alu = {imm_q[15:0], 16'd0};
            default: alu = 32'd0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= 32'd0;
         b_q    <= 32'd0;
         imm_q  <= 32'd0;
         ir_q   <= 32'd0;
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
         md_hi  <= 32'd0;
         md_lo  <= 32'd0;
         md_d   <= 32'd0;
         md_div <= 1'b0;
         cnt    <= '0;
         state  <= ST_IDLE;
      end else begin
         if (!stall) begin
            a_q   <= A_i;
            b_q   <= B_i;
            imm_q <= Imm_i;
            ir_q  <= IR_i;
         end
         case (state)
            ST_IDLE: begin
               if (is_md) begin
                  md_hi  <= 32'd0;
                  md_lo  <= a_q;
                  md_d   <= b_q;
                  md_div <= (funct == FN_DIVU);
                  cnt    <= CNT_LAST;
                  state  <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               md_hi <= step_hi;
               md_lo <= step_lo;
               cnt   <= cnt - 1'b1;
               if (cnt == '0) begin
                  hi_q  <= step_hi;
                  lo_q  <= step_lo;
                  state <= ST_DONE;
               end
            end
            // DONE still holds the MD instruction; returning to IDLE as the next one loads avoids a restart.
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/ex_seg.md
Name: ex_seg

Overview:
- Execute stage of the 5-stage R/I/J pipeline; sits between the ID stage and MEMSeg.
- Latches the decoded operands and the instruction and computes the ALU result or effective address.
- Holds the HI/LO registers and an iterative 32-cycle unsigned multiply/divide unit.
- While a MULTU/DIVU runs, asserts `stall` upstream and feeds NOP bubbles downstream.

Parameters:
- MD_CYCLES, 32, number of multiply/divide iterations (one bit per cycle; fixed at 32 for 32-bit operands).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- A_i  input  32  rs operand from ID.
- B_i  input  32  rt operand from ID.
- Imm_i  input  32  sign-extended immediate from ID.
- IR_i  input  32  instruction from ID.
- stall  output  1  1 = ID/IF must hold their current outputs; ex_seg ignores its inputs this cycle.
- ALUo_Out  output  32  ALU result / effective address to MEMSeg ALUo_In_i.
- B_Out  output  32  latched rt value to MEMSeg B_i (store data).
- IR_Out  output  32  instruction to MEMSeg IR_i; 0 (NOP) while stall=1.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. No other clock or reset.
- Reset: on a rising edge with rst=1:
  - A, B, Imm, IR, HI, LO, the MD working registers and the counter clear to 0.
  - State goes to IDLE.
  - Resulting outputs: stall=0, ALUo_Out=0, B_Out=0, IR_Out=0.
  - Reset overrides everything, including a mid-operation BUSY; the aborted result is discarded and HI/LO=0.
- Input register: when stall=0, each rising edge loads A<=A_i, B<=B_i, Imm<=Imm_i, IR<=IR_i. When stall=1 the register holds.
- Decode of the latched IR: opcode = IR[31:26], funct = IR[5:0], shamt = IR[10:6].
- R-type (opcode 0), ALUo = f(A, B):
  - add 0x20: A+B, wrap, no overflow trap.
  - sub 0x22: A-B.
  - and 0x24, or 0x25, xor 0x26.
  - slt 0x2A: signed compare, result 1/0.
  - sltu 0x2B: unsigned compare.
  - sll 0x00: B<<shamt. srl 0x02: B>>shamt logical.
  - mfhi 0x10: HI. mflo 0x12: LO.
  - multu 0x19, divu 0x1B: ALUo=0.
- I-type, ALUo = f(A, Imm):
  - addi 0x08: A+Imm.
  - slti 0x0A: signed compare.
  - andi 0x0C / ori 0x0D: use zero-extended Imm[15:0].
  - lui 0x0F: {Imm[15:0], 16'h0}.
  - lw 0x23 / sw 0x2B: A+Imm.
- Any other opcode: ALUo=0, IR passed unchanged.
- B_Out = B always.
- MD state machine (states IDLE, BUSY, DONE):
  - IDLE: if the latched IR is MULTU/DIVU, then stall=1, IR_Out=0. Next edge: load working registers from A, B; counter <= 31; go to BUSY. Otherwise stall=0 and IR_Out=IR.
  - BUSY: stall=1, IR_Out=0.
    - MULTU: one shift-add step per cycle.
    - DIVU: one restoring shift-subtract step per cycle.
    - Counter decrements each edge. The edge with counter==0 performs the final step, writes HI/LO, and goes to DONE.
  - DONE: stall=0, IR_Out=IR (the MULTU/DIVU passes to MEM as a no-write instruction). Next edge loads the next instruction and goes to IDLE.
- Latency: a MULTU/DIVU holds stall=1 for exactly 33 consecutive cycles (1 IDLE + 32 BUSY).
- MD results:
  - MULTU: {HI, LO} = A*B as a 64-bit unsigned product.
  - DIVU: LO = A/B, HI = A%B, unsigned.
  - DIVU with B=0: LO=0xFFFFFFFF, HI=A. No exception.
- HI/LO change only on the final BUSY edge or on reset.
- MFHI/MFLO hazard: MFHI/MFLO immediately following MULTU/DIVU reads the new values; no extra stall is needed.
- Back-to-back MD instructions: each restarts from IDLE after DONE; there is no overlap.

Test Plan:
- Reset, then apply IR=add $3,$1,$2 (0x00221820), A=5, B=7 -> after 1 edge: ALUo_Out=12, IR_Out=0x00221820, stall=0.
- lw, IR opcode 0x23, A=0x100, Imm=0xFFFFFFFC -> ALUo_Out=0x000000FC, B_Out=B. lui with Imm=0x1234 -> ALUo_Out=0x12340000.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF:
  - stall=1 and IR_Out=0 for exactly 33 cycles, then the DONE cycle shows the multu IR.
  - A following mfhi gives 0xFFFFFFFE; mflo gives 0x00000001.
- divu A=100, B=7 -> mflo=14, mfhi=2. divu A=9, B=0 -> mflo=0xFFFFFFFF, mfhi=9.
- rst=1 at BUSY cycle 10 of a multu -> next edge: stall=0, IR_Out=0, HI=LO=0 (mfhi returns 0), state IDLE.
- Inputs toggled while stall=1 -> ignored: the latched A/B/IR are unchanged, and the instruction presented at the DONE edge is the one taken.
